// File: rtl/head_table_dispatch_pkg.sv
// Shared types for the hash-table front stage: command encoding, task payloads
// and the head-table RAM word.
package head_table_dispatch_pkg;

  localparam int unsigned TABLE_ADDR_WIDTH = 8;
  localparam int unsigned BUCKET_WIDTH     = 8;
  localparam int unsigned KEY_WIDTH        = 32;
  localparam int unsigned VALUE_WIDTH      = 32;
  localparam int unsigned ILL_CNT_WIDTH    = 16;

  typedef enum logic [1:0] {
    OP_SEARCH = 2'd0,
    OP_INSERT = 2'd1,
    OP_DELETE = 2'd2
  } ht_cmd_t;

  typedef enum logic [1:0] {
    IDLE_S      = 2'd0,
    READ_HEAD_S = 2'd1,
    DISPATCH_S  = 2'd2
  } disp_state_t;

  typedef struct packed {
    ht_cmd_t                 cmd;
    logic [KEY_WIDTH-1:0]    key;
    logic [VALUE_WIDTH-1:0]  value;
    logic [BUCKET_WIDTH-1:0] bucket;
  } ht_pdata_t;

  typedef struct packed {
    logic [TABLE_ADDR_WIDTH-1:0] ptr;
    logic                        ptr_val;
  } head_ram_data_t;

  typedef struct packed {
    ht_cmd_t                     cmd;
    logic [KEY_WIDTH-1:0]        key;
    logic [VALUE_WIDTH-1:0]      value;
    logic [BUCKET_WIDTH-1:0]     bucket;
    logic [TABLE_ADDR_WIDTH-1:0] head_ptr;
    logic                        head_ptr_val;
  } ht_data_task_t;

endpackage

// File: rtl/ht_cmd_router.sv
// Combinational command decode: raises the selected engine's valid while
// dispatching, flags unknown commands and muxes back the selected ready.
module ht_cmd_router
  import head_table_dispatch_pkg::*;
(
  input  ht_cmd_t cmd,
  input  logic    dispatch_en,
  input  logic    search_ready,
  input  logic    insert_ready,
  input  logic    delete_ready,
  output logic    search_valid_c,
  output logic    insert_valid_c,
  output logic    delete_valid_c,
  output logic    illegal_c,
  output logic    sel_ready_c
);

  always_comb begin
    search_valid_c = 1'b0;
    insert_valid_c = 1'b0;
    delete_valid_c = 1'b0;
    illegal_c      = 1'b0;
    sel_ready_c    = 1'b0;
    if (dispatch_en) begin
      case (cmd)
        OP_SEARCH: begin
          search_valid_c = 1'b1;
          sel_ready_c    = search_ready;
        end
        OP_INSERT: begin
          insert_valid_c = 1'b1;
          sel_ready_c    = insert_ready;
        end
        OP_DELETE: begin
          delete_valid_c = 1'b1;
          sel_ready_c    = delete_ready;
        end
        default: illegal_c = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/head_table_dispatch.sv
// Front stage of the hash-table path: reads a bucket's head pointer and hands
// the completed task to exactly one engine, one task at a time.
module head_table_dispatch
  import head_table_dispatch_pkg::*;
#(
  parameter int unsigned RAM_LATENCY = 2,
  parameter int unsigned A_WIDTH     = TABLE_ADDR_WIDTH,
  parameter int unsigned B_WIDTH     = BUCKET_WIDTH
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  ht_pdata_t                task_i,
  input  logic                     task_valid_i,
  output logic                     task_ready_o,
  output logic [B_WIDTH-1:0]       head_rd_addr_o,
  output logic                     head_rd_en_o,
  input  head_ram_data_t           head_rd_data_i,
  output ht_data_task_t            task_o,
  output logic                     search_valid_o,
  output logic                     insert_valid_o,
  output logic                     delete_valid_o,
  input  logic                     search_ready_i,
  input  logic                     insert_ready_i,
  input  logic                     delete_ready_i,
  output logic [ILL_CNT_WIDTH-1:0] illegal_cmd_cnt_o
);

  localparam int unsigned CNT_WIDTH = 3;
  // Counter starts at 0 in the first READ_HEAD_S cycle, so data lands at LATENCY-1.
  localparam logic [CNT_WIDTH-1:0] LAT_LAST = CNT_WIDTH'(RAM_LATENCY - 1);
  localparam logic [ILL_CNT_WIDTH-1:0] ILL_CNT_MAX = '1;

  disp_state_t              state_q;
  disp_state_t              state_d;
  ht_pdata_t                task_locked;
  logic [CNT_WIDTH-1:0]     lat_cnt_q;
  logic [ILL_CNT_WIDTH-1:0] illegal_cnt_q;

  logic all_idle;
  logic accept;
  logic head_capture;
  logic dispatch_en;
  logic sel_ready;
  logic illegal;

  assign all_idle     = search_ready_i & insert_ready_i & delete_ready_i;
  assign task_ready_o = (state_q == IDLE_S) && all_idle;
  assign accept       = task_valid_i && task_ready_o && !rst_i;
  assign head_capture = (state_q == READ_HEAD_S) && (lat_cnt_q == LAT_LAST);
  assign dispatch_en  = (state_q == DISPATCH_S);

  assign head_rd_en_o      = accept;
  assign head_rd_addr_o    = accept ? B_WIDTH'(task_i.bucket) : '0;
  assign illegal_cmd_cnt_o = illegal_cnt_q;

  ht_cmd_router u_router (
    .cmd            (task_o.cmd),
    .dispatch_en    (dispatch_en),
    .search_ready   (search_ready_i),
    .insert_ready   (insert_ready_i),
    .delete_ready   (delete_ready_i),
    .search_valid_c (search_valid_o),
    .insert_valid_c (insert_valid_o),
    .delete_valid_c (delete_valid_o),
    .illegal_c      (illegal),
    .sel_ready_c    (sel_ready)
  );

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE_S;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE_S:      if (accept)              state_d = READ_HEAD_S;
      READ_HEAD_S: if (head_capture)        state_d = DISPATCH_S;
      DISPATCH_S:  if (sel_ready || illegal) state_d = IDLE_S;
      default:                              state_d = IDLE_S;
    endcase
  end

  // Task capture, latency counter and head-pointer merge
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      task_locked <= '0;
      task_o      <= '0;
      lat_cnt_q   <= '0;
    end else begin
      if (accept) begin
        task_locked <= task_i;
        lat_cnt_q   <= '0;
      end else if (state_q == READ_HEAD_S) begin
        lat_cnt_q <= lat_cnt_q + CNT_WIDTH'(1);
      end
      if (head_capture) begin
        task_o.cmd          <= task_locked.cmd;
        task_o.key          <= task_locked.key;
        task_o.value        <= task_locked.value;
        task_o.bucket       <= task_locked.bucket;
        task_o.head_ptr     <= TABLE_ADDR_WIDTH'(A_WIDTH'(head_rd_data_i.ptr));
        task_o.head_ptr_val <= head_rd_data_i.ptr_val;
      end
    end
  end

  // Saturating count of tasks dropped for an unknown command
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      illegal_cnt_q <= '0;
    end else if (illegal && (illegal_cnt_q != ILL_CNT_MAX)) begin
      illegal_cnt_q <= illegal_cnt_q + ILL_CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_head_table_dispatch.sv
// Directed bench for head_table_dispatch with a head-RAM model and a scoreboard
// of expected dispatches.
module tb_head_table_dispatch;
  import head_table_dispatch_pkg::*;

  localparam int unsigned L = 2;

  logic           clk = 1'b0;
  logic           rst_i;
  ht_pdata_t      task_i;
  logic           task_valid_i;
  logic           task_ready_o;
  logic [7:0]     head_rd_addr_o;
  logic           head_rd_en_o;
  head_ram_data_t head_rd_data_i;
  ht_data_task_t  task_o;
  logic           search_valid_o, insert_valid_o, delete_valid_o;
  logic           search_ready_i, insert_ready_i, delete_ready_i;
  logic [15:0]    illegal_cmd_cnt_o;

  always #5 clk = ~clk;

  head_table_dispatch #(.RAM_LATENCY(L)) dut (
    .clk_i             (clk),
    .rst_i             (rst_i),
    .task_i            (task_i),
    .task_valid_i      (task_valid_i),
    .task_ready_o      (task_ready_o),
    .head_rd_addr_o    (head_rd_addr_o),
    .head_rd_en_o      (head_rd_en_o),
    .head_rd_data_i    (head_rd_data_i),
    .task_o            (task_o),
    .search_valid_o    (search_valid_o),
    .insert_valid_o    (insert_valid_o),
    .delete_valid_o    (delete_valid_o),
    .search_ready_i    (search_ready_i),
    .insert_ready_i    (insert_ready_i),
    .delete_ready_i    (delete_ready_i),
    .illegal_cmd_cnt_o (illegal_cmd_cnt_o)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Head RAM contents: bucket 5 -> 0x1A, bucket 9 holds an empty chain
  function automatic head_ram_data_t ram_word(input logic [7:0] b);
    head_ram_data_t w;
    w.ptr     = (b == 8'd5) ? 8'h1A : 8'(b * 8'd3 + 8'd1);
    w.ptr_val = (b != 8'd9);
    return w;
  endfunction

  // Two-stage read pipeline; junk is driven outside the valid cycle
  head_ram_data_t d1, d2;
  logic v1 = 1'b0, v2 = 1'b0;
  always @(posedge clk) begin
    d1 <= ram_word(head_rd_addr_o);
    v1 <= head_rd_en_o;
    d2 <= d1;
    v2 <= v1;
  end
  assign head_rd_data_i = v2 ? d2 : '{ptr: 8'hEE, ptr_val: 1'b1};

  typedef struct {
    ht_data_task_t t;
    int            eng;
    int            acc;
  } exp_t;
  exp_t q[$];

  // Monitor: pushes on accept, pops on engine handshake
  logic          m_acc, m_any, m_hs, prev_any;
  int            m_eng;
  exp_t          m_e;
  ht_data_task_t prev_task;
  head_ram_data_t m_w;

  always @(negedge clk) begin
    if (rst_i) begin
      prev_any = 1'b0;
    end else begin
      m_acc = task_valid_i && task_ready_o;
      chk("rd_en", 128'(head_rd_en_o), 128'(m_acc));
      if (m_acc) begin
        chk("rd_addr", 128'(head_rd_addr_o), 128'(task_i.bucket));
        if (task_i.cmd inside {OP_SEARCH, OP_INSERT, OP_DELETE}) begin
          m_w = ram_word(task_i.bucket);
          m_e.t = '{cmd: task_i.cmd, key: task_i.key, value: task_i.value,
                    bucket: task_i.bucket, head_ptr: m_w.ptr, head_ptr_val: m_w.ptr_val};
          m_e.eng = int'(task_i.cmd);
          m_e.acc = cyc;
          q.push_back(m_e);
        end
      end
      m_any = search_valid_o | insert_valid_o | delete_valid_o;
      m_hs  = (search_valid_o && search_ready_i) || (insert_valid_o && insert_ready_i) ||
              (delete_valid_o && delete_ready_i);
      if (m_any) begin
        chk("onehot", 128'($countones({search_valid_o, insert_valid_o, delete_valid_o})), 128'(1));
        chk("unexpected_valid", 128'(q.size() > 0), 128'(1));
        if (!prev_any && q.size() > 0)
          chk("dispatch_latency", 128'(cyc), 128'(q[0].acc + L + 1));
        else if (prev_any)
          chk("task_stable", 128'(task_o), 128'(prev_task));
        if (m_hs && q.size() > 0) begin
          m_e   = q.pop_front();
          m_eng = search_valid_o ? 0 : (insert_valid_o ? 1 : 2);
          chk("task_o", 128'(task_o), 128'(m_e.t));
          chk("engine", 128'(m_eng), 128'(m_e.eng));
        end
      end
      prev_any  = m_any && !m_hs;
      prev_task = task_o;
    end
  end

  task automatic drive_task(input ht_cmd_t c, input logic [31:0] k, input logic [31:0] v,
                            input logic [7:0] b);
    task_i       = '{cmd: c, key: k, value: v, bucket: b};
    task_valid_i = 1'b1;
  endtask

  task automatic wait_accept();
    logic got;
    got = 1'b0;
    for (int n = 0; n < 60 && !got; n++) begin
      @(negedge clk);
      got = task_ready_o;
      @(posedge clk);
      #1;
    end
    task_valid_i = 1'b0;
    chk("accept_timeout", 128'(got), 128'(1));
  endtask

  task automatic wait_idle();
    logic done;
    done = 1'b0;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      done = (q.size() == 0) && task_ready_o;
    end
    @(posedge clk);
    #1;
    chk("idle_timeout", 128'(done), 128'(1));
  endtask

  task automatic send(input ht_cmd_t c, input logic [31:0] k, input logic [31:0] v,
                      input logic [7:0] b);
    drive_task(c, k, v, b);
    wait_accept();
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    rst_i          = 1'b1;
    task_i         = '0;
    task_valid_i   = 1'b0;
    search_ready_i = 1'b1;
    insert_ready_i = 1'b1;
    delete_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;

    @(negedge clk);
    chk("rst_ready", 128'(task_ready_o), 128'(1));
    chk("rst_valids", 128'({search_valid_o, insert_valid_o, delete_valid_o}), 128'(0));
    chk("rst_task_o", 128'(task_o), 128'(0));
    chk("rst_ill_cnt", 128'(illegal_cmd_cnt_o), 128'(0));
    @(posedge clk);
    #1;

    // Search on bucket 5 -> head_ptr 0x1A
    send(OP_SEARCH, 32'h1111_0001, 32'hAAAA_0001, 8'd5);

    // Delete with the engine stalling for four dispatch cycles
    drive_task(OP_DELETE, 32'h2222_0002, 32'hBBBB_0002, 8'd7);
    wait_accept();
    delete_ready_i = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      seen = delete_valid_o;
    end
    chk("del_valid_rise", 128'(seen), 128'(1));
    repeat (3) begin
      @(negedge clk);
      chk("del_hold", 128'(delete_valid_o), 128'(1));
    end
    @(posedge clk);
    #1 delete_ready_i = 1'b1;
    @(negedge clk);
    chk("del_handshake", 128'(delete_valid_o), 128'(1));
    @(posedge clk);
    #1 delete_ready_i = 1'b0;
    drive_task(OP_SEARCH, 32'h3333_0003, 32'hCCCC_0003, 8'd2);
    repeat (3) begin
      @(negedge clk);
      chk("busy_ready", 128'(task_ready_o), 128'(0));
      chk("busy_del_valid", 128'(delete_valid_o), 128'(0));
    end
    @(posedge clk);
    #1 delete_ready_i = 1'b1;
    wait_accept();
    wait_idle();

    // Empty chain forwarded unchanged
    send(OP_INSERT, 32'h4444_0004, 32'hDDDD_0004, 8'd9);

    // Unknown command dropped and counted, then saturation
    send(ht_cmd_t'(2'd3), 32'h5555_0005, 32'hEEEE_0005, 8'd4);
    chk("ill_cnt_1", 128'(illegal_cmd_cnt_o), 128'(1));
    force dut.illegal_cnt_q = 16'hFFFE;
    @(posedge clk);
    #1 release dut.illegal_cnt_q;
    send(ht_cmd_t'(2'd3), 32'h5555_0006, 32'hEEEE_0006, 8'd4);
    chk("ill_cnt_max", 128'(illegal_cmd_cnt_o), 128'(16'hFFFF));
    send(ht_cmd_t'(2'd3), 32'h5555_0007, 32'hEEEE_0007, 8'd4);
    chk("ill_cnt_sat", 128'(illegal_cmd_cnt_o), 128'(16'hFFFF));

    // Reset while the head read is in flight
    drive_task(OP_SEARCH, 32'h6666_0008, 32'hFFFF_0008, 8'd3);
    wait_accept();
    rst_i = 1'b1;
    @(posedge clk);
    #1 rst_i = 1'b0;
    q.delete();
    @(negedge clk);
    chk("mid_rst_ready", 128'(task_ready_o), 128'(1));
    chk("mid_rst_valids", 128'({search_valid_o, insert_valid_o, delete_valid_o}), 128'(0));
    chk("mid_rst_task_o", 128'(task_o), 128'(0));
    chk("mid_rst_ill_cnt", 128'(illegal_cmd_cnt_o), 128'(0));
    repeat (5) @(posedge clk);
    #1;
    send(OP_INSERT, 32'h7777_0009, 32'h1234_0009, 8'd6);

    // A few back-to-back tasks with varied payloads
    for (int i = 0; i < 6; i++)
      send(ht_cmd_t'(2'(i % 3)), $urandom, $urandom, 8'($urandom_range(0, 255)));

    chk("queue_drained", 128'(q.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
